// File: rtl/data_ram.sv
// rtl/data_ram.sv - word-addressed single-port data memory with a registered read port
// Every word clears on asynchronous reset, so the array is built from flops, not an inferred RAM.
module data_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [DATA_W-1:0] dmem_data,
    input  logic              dmem_re,
    input  logic              dmem_we,
    output logic [DATA_W-1:0] dmem_out
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] dmem_out_q;
    logic [DATA_W-1:0] dmem_out_d;
    logic [DATA_W-1:0] rd_word;
    logic              addr_hit;

    // Decode by comparison, so out-of-range addresses match no word: writes drop, reads give 0.
    always_comb begin
        rd_word  = '0;
        addr_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (dmem_addr == ADDR_W'(i)) begin
                rd_word  = mem_q[i];
                addr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (dmem_we && (dmem_addr == ADDR_W'(i))) begin
                mem_d[i] = dmem_data;
            end
        end
    end

    // Write-first: a read that shares its edge with a write returns the incoming data.
    always_comb begin
        dmem_out_d = dmem_out_q;
        if (dmem_re) begin
            dmem_out_d = (dmem_we && addr_hit) ? dmem_data : rd_word;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dmem_out_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            dmem_out_q <= dmem_out_d;
        end
    end

    assign dmem_out = dmem_out_q;

endmodule

// File: tb/tb_data_ram.sv
// tb/tb_data_ram.sv - randomized self-checking bench for data_ram against an array model
module tb_data_ram;

    logic        clk;
    logic        nrst;
    logic [8:0]  dmem_addr;
    logic [31:0] dmem_data;
    logic        dmem_re;
    logic        dmem_we;
    logic [31:0] dmem_out;

    logic [31:0] model [512];
    logic [31:0] exp_out;
    int          passed;
    int          total;

    data_ram #(.DATA_W(32), .ADDR_W(9), .DEPTH(512)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .dmem_addr (dmem_addr),
        .dmem_data (dmem_data),
        .dmem_re   (dmem_re),
        .dmem_we   (dmem_we),
        .dmem_out  (dmem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    task automatic model_clear();
        for (int i = 0; i < 512; i++) model[i] = '0;
        exp_out = '0;
    endtask

    // One memory cycle; the model applies read-old-data unless the same edge writes (write-first).
    task automatic op(input logic re, input logic we, input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        dmem_re   = re;
        dmem_we   = we;
        dmem_addr = a;
        dmem_data = d;
        @(posedge clk);
        #1;
        if (re) exp_out = we ? d : model[a];
        if (we) model[a] = d;
        dmem_re = 1'b0;
        dmem_we = 1'b0;
    endtask

    task automatic test_reset();
        logic [8:0] addrs [3];
        addrs[0] = 9'd0;
        addrs[1] = 9'd1;
        addrs[2] = 9'd511;
        total++;
        if (dmem_out !== 32'h0) $display("FAIL reset_initial: dmem_out=%h expected=%h", dmem_out, 32'h0);
        else passed++;
        @(negedge clk);
        nrst = 1'b1;
        op(1'b0, 1'b1, 9'd0, 32'hCAFE0000);
        op(1'b0, 1'b1, 9'd1, 32'hCAFE0001);
        op(1'b0, 1'b1, 9'd511, 32'hCAFE01FF);
        op(1'b1, 1'b0, 9'd1, 32'h0);
        total++;
        if (dmem_out !== 32'hCAFE0001) $display("FAIL reset_prior_read: dmem_out=%h expected=%h", dmem_out, 32'hCAFE0001);
        else passed++;
        @(negedge clk);
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        total++;
        if (dmem_out !== 32'h0) $display("FAIL reset_held: dmem_out=%h expected=%h", dmem_out, 32'h0);
        else passed++;
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op(1'b1, 1'b0, addrs[k], 32'h0);
            total++;
            if (dmem_out !== 32'h0) $display("FAIL reset_read_addr%0d: dmem_out=%h expected=%h", addrs[k], dmem_out, 32'h0);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        op(1'b0, 1'b1, 9'h004, 32'hDEADBEEF);
        op(1'b1, 1'b0, 9'h004, 32'h0);
        total++;
        if (dmem_out !== 32'hDEADBEEF) $display("FAIL write_read: dmem_out=%h expected=%h", dmem_out, 32'hDEADBEEF);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            op(1'b0, 1'b0, 9'($urandom_range(0, 511)), $urandom);
            total++;
            if (dmem_out !== 32'hDEADBEEF) $display("FAIL hold_cycle%0d: dmem_out=%h expected=%h", k, dmem_out, 32'hDEADBEEF);
            else passed++;
        end
    endtask

    task automatic test_write_first();
        op(1'b0, 1'b1, 9'd10, 32'h11111111);
        op(1'b1, 1'b1, 9'd10, 32'h22222222);
        total++;
        if (dmem_out !== 32'h22222222) $display("FAIL write_first: dmem_out=%h expected=%h", dmem_out, 32'h22222222);
        else passed++;
        op(1'b1, 1'b0, 9'd4, 32'h0);
        op(1'b1, 1'b0, 9'd10, 32'h0);
        total++;
        if (dmem_out !== 32'h22222222) $display("FAIL write_first_array: dmem_out=%h expected=%h", dmem_out, 32'h22222222);
        else passed++;
    endtask

    task automatic test_boundaries();
        op(1'b0, 1'b1, 9'd511, 32'hA5A5A5A5);
        op(1'b0, 1'b1, 9'd0, 32'h5A5A5A5A);
        op(1'b1, 1'b0, 9'd511, 32'h0);
        total++;
        if (dmem_out !== 32'hA5A5A5A5) $display("FAIL boundary_511: dmem_out=%h expected=%h", dmem_out, 32'hA5A5A5A5);
        else passed++;
        op(1'b1, 1'b0, 9'd0, 32'h0);
        total++;
        if (dmem_out !== 32'h5A5A5A5A) $display("FAIL boundary_0: dmem_out=%h expected=%h", dmem_out, 32'h5A5A5A5A);
        else passed++;
    endtask

    task automatic test_write_only();
        op(1'b1, 1'b0, 9'd4, 32'h0);
        total++;
        if (dmem_out !== 32'hDEADBEEF) $display("FAIL write_only_pre: dmem_out=%h expected=%h", dmem_out, 32'hDEADBEEF);
        else passed++;
        op(1'b0, 1'b1, 9'd5, 32'h12345678);
        total++;
        if (dmem_out !== 32'hDEADBEEF) $display("FAIL write_only_hold: dmem_out=%h expected=%h", dmem_out, 32'hDEADBEEF);
        else passed++;
        op(1'b1, 1'b0, 9'd5, 32'h0);
        total++;
        if (dmem_out !== 32'h12345678) $display("FAIL write_only_stored: dmem_out=%h expected=%h", dmem_out, 32'h12345678);
        else passed++;
    endtask

    // Back-to-back random traffic concentrated on a few addresses plus the edges of the array.
    task automatic test_back_to_back();
        logic [8:0]  a;
        logic [31:0] d;
        logic        re;
        logic        we;
        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0:       a = 9'd0;
                1:       a = 9'd511;
                default: a = 9'($urandom_range(0, 15));
            endcase
            d  = $urandom;
            re = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            op(re, we, a, d);
            total++;
            if (dmem_out !== exp_out)
                $display("FAIL random_op%0d re=%0b we=%0b addr=%0d: dmem_out=%h expected=%h", k, re, we, a, dmem_out, exp_out);
            else passed++;
        end
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b0, 9'(i), 32'h0);
            total++;
            if (dmem_out !== model[i]) $display("FAIL random_sweep_addr%0d: dmem_out=%h expected=%h", i, dmem_out, model[i]);
            else passed++;
        end
    endtask

    task automatic test_mid_reset();
        op(1'b0, 1'b1, 9'd20, 32'h0BADF00D);
        op(1'b1, 1'b0, 9'd20, 32'h0);
        total++;
        if (dmem_out !== 32'h0BADF00D) $display("FAIL mid_reset_pre: dmem_out=%h expected=%h", dmem_out, 32'h0BADF00D);
        else passed++;
        @(negedge clk);
        dmem_we   = 1'b1;
        dmem_addr = 9'd21;
        dmem_data = 32'h77777777;
        @(posedge clk);
        #2;
        dmem_addr = 9'd22;
        dmem_data = 32'h88888888;
        nrst = 1'b0;
        #1;
        total++;
        if (dmem_out !== 32'h0) $display("FAIL mid_reset_async: dmem_out=%h expected=%h", dmem_out, 32'h0);
        else passed++;
        @(posedge clk);
        #1;
        dmem_we = 1'b0;
        model_clear();
        @(negedge clk);
        nrst = 1'b1;
        for (int k = 20; k < 23; k++) begin
            op(1'b1, 1'b0, 9'(k), 32'h0);
            total++;
            if (dmem_out !== 32'h0) $display("FAIL mid_reset_read_addr%0d: dmem_out=%h expected=%h", k, dmem_out, 32'h0);
            else passed++;
        end
        op(1'b1, 1'b0, 9'd4, 32'h0);
        total++;
        if (dmem_out !== 32'h0) $display("FAIL mid_reset_read_addr4: dmem_out=%h expected=%h", dmem_out, 32'h0);
        else passed++;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        nrst      = 1'b0;
        dmem_addr = '0;
        dmem_data = '0;
        dmem_re   = 1'b0;
        dmem_we   = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_write_first();
        test_boundaries();
        test_write_only();
        test_back_to_back();
        test_mid_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
